// File: rtl/pseudo_sensor_pkg.sv
// Shared definitions for the pseudo-sensor timing generator: FSM states,
// test-pattern codes and a small constant helper for counter sizing.
package pseudo_sensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_RAMP   = 2'd0,
    PAT_RAMP_F = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_CONST  = 2'd3
  } pattern_e;

  // Value driven by the constant test pattern (truncated/extended to PIX_W).
  localparam logic [7:0] CONST_PIXEL = 8'hA5;

  // Largest of four values, used to size the shared x/y/blank counters.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pseudo_pix_pattern.sv
// Combinational test-pattern generator: maps raster position, frame count
// and pattern code to a pixel value. The caller registers the result.
module pseudo_pix_pattern
  import pseudo_sensor_pkg::*;
#(
  parameter int CW    = 7,
  parameter int PIX_W = 8
) (
  input  logic [CW-1:0]    x_i,
  input  logic [CW-1:0]    y_i,
  input  logic [PIX_W-1:0] frame_cnt_i,
  input  pattern_e         pattern_i,
  output logic [PIX_W-1:0] pix_o
);

  // Select the pixel value for the current pattern; sums wrap modulo 2^PIX_W.
  always_comb begin
    pix_o = {PIX_W{1'b0}};
    case (pattern_i)
      PAT_RAMP:   pix_o = PIX_W'(x_i) + PIX_W'(y_i);
      PAT_RAMP_F: pix_o = PIX_W'(x_i) + PIX_W'(y_i) + frame_cnt_i;
      PAT_CHECK:  pix_o = {PIX_W{x_i[2] ^ y_i[2]}};
      PAT_CONST:  pix_o = PIX_W'(CONST_PIXEL);
      default:    pix_o = {PIX_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/pseudo_sensor_timing_gen.sv
// Synthetic camera source: raster timing FSM with programmable active area
// and blanking, producing valid/data plus sof/eol/eof markers. All outputs
// are registered from the next-state values so they line up with the state.
module pseudo_sensor_timing_gen
  import pseudo_sensor_pkg::*;
#(
  parameter int H_ACTIVE = 32,
  parameter int V_ACTIVE = 32,
  parameter int H_BLANK  = 8,
  parameter int V_BLANK  = 64,
  parameter int PIX_W    = 8,
  parameter int FCNT_W   = 16
) (
  input  logic              p_clk,
  input  logic              arst_p_n,
  input  logic              en,
  input  logic [1:0]        pattern_sel,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy
);

  localparam int CW = $clog2(max4(H_ACTIVE, V_ACTIVE, H_BLANK, V_BLANK) + 1);

  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // x_q doubles as the blanking cycle counter in HBLANK/VBLANK.
  state_e      state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  pattern_e    pat_q, pat_d;

  logic              pix_valid_q, sof_q, eol_q, eof_q, busy_q;
  logic [PIX_W-1:0]  pix_data_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic              pix_valid_d, sof_d, eol_d, eof_d, busy_d;
  logic [PIX_W-1:0]  pix_data_d;

  // Next-state and counter logic; en and pattern_sel only matter at frame starts.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pat_d   = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ACTIVE;
          x_d     = CNT_ZERO;
          y_d     = CNT_ZERO;
          pat_d   = pattern_e'(pattern_sel);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (x_q == H_LAST) begin
          state_d = ST_HBLANK;
          x_d     = CNT_ZERO;
        end else begin
          x_d = x_q + CNT_ONE;
        end
      end
      ST_HBLANK: begin
        if (x_q == HB_LAST) begin
          x_d = CNT_ZERO;
          if (y_q == V_LAST) begin
            state_d = ST_VBLANK;
          end else begin
            state_d = ST_ACTIVE;
            y_d     = y_q + CNT_ONE;
          end
        end else begin
          x_d = x_q + CNT_ONE;
        end
      end
      ST_VBLANK: begin
        if (x_q == VB_LAST) begin
          x_d = CNT_ZERO;
          y_d = CNT_ZERO;
          if (en) begin
            state_d = ST_ACTIVE;
            pat_d   = pattern_e'(pattern_sel);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          x_d = x_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = CNT_ZERO;
        y_d     = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so registered outputs match state_q.
  always_comb begin
    pix_valid_d = (state_d == ST_ACTIVE);
    sof_d       = pix_valid_d && (x_d == CNT_ZERO) && (y_d == CNT_ZERO);
    eol_d       = pix_valid_d && (x_d == H_LAST);
    eof_d       = eol_d && (y_d == V_LAST);
    busy_d      = (state_d != ST_IDLE);
  end

  pseudo_pix_pattern #(
    .CW    (CW),
    .PIX_W (PIX_W)
  ) u_pattern (
    .x_i         (x_d),
    .y_i         (y_d),
    .frame_cnt_i (frame_cnt_q[PIX_W-1:0]),
    .pattern_i   (pat_d),
    .pix_o       (pix_data_d)
  );

  // Timing FSM, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge p_clk or negedge arst_p_n) begin
    if (!arst_p_n) begin
      state_q     <= ST_IDLE;
      x_q         <= CNT_ZERO;
      y_q         <= CNT_ZERO;
      pat_q       <= PAT_RAMP;
      pix_valid_q <= 1'b0;
      pix_data_q  <= {PIX_W{1'b0}};
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= {FCNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pat_q       <= pat_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_valid_d ? pix_data_d : {PIX_W{1'b0}};
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      frame_cnt_q <= eof_q ? (frame_cnt_q + FCNT_W'(1)) : frame_cnt_q;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule
